// File: rtl/sdram_port_arbiter_pkg.sv
// Shared SDRAM types (burst lengths, beat data, access bundle) and arbiter
// constants used by the port arbiter and its round-robin search.
package sdram_port_arbiter_pkg;

  typedef enum logic [1:0] {BURST_1, BURST_2, BURST_4, BURST_8} burst_t;

  localparam int N_BURSTS [4] = '{1, 2, 4, 8};

  typedef logic [31:0] data_t;

  typedef struct packed {
    logic [23:0] addr;
    data_t       data;
    logic [3:0]  mask;
  } dram_access_t;

  typedef enum logic {ARB_IDLE, ARB_ACTIVE} arb_state_t;

  // Index width that stays legal (>=1) for a single-entry range.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first set request at or after ptr,
// wrapping from N-1 back to 0.
module rr_arbiter
  import sdram_port_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] gnt_idx,
  output logic          any
);

  logic found;
  int   j;

  always_comb begin
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!found && req[j]) begin
        found   = 1'b1;
        gnt_idx = PW'(j);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin responder that forwards one burst at a time from N_DST cache
// ports to the SDRAM controller core and routes acks/read data back.
module sdram_port_arbiter
  import sdram_port_arbiter_pkg::*;
#(
  parameter int     N_DST = 4,
  parameter burst_t BURST = BURST_8
) (
  input  logic                           CLK,
  input  logic                           RESET_IN,
  input  logic         [N_DST-1:0]       SRC_WRITE_IN,
  input  dram_access_t [N_DST-1:0]       SRC_ACS_IN,
  input  logic         [N_DST-1:0]       SRC_REQ_IN,
  output logic         [N_DST-1:0]       SRC_ACK_OUT,
  output data_t        [N_DST-1:0]       SRC_DATA_OUT,
  output logic                           MEM_WRITE_OUT,
  output dram_access_t                   MEM_ACS_OUT,
  output logic                           MEM_REQ_OUT,
  input  logic                           MEM_ACK_IN,
  input  data_t                          MEM_DATA_IN,
  output logic                           ERR_OUT
);

  localparam int NB = N_BURSTS[BURST];
  localparam int CW = idx_w(NB);
  localparam int PW = idx_w(N_DST);

  arb_state_t    state;
  logic [PW-1:0] grant, rr_ptr, arb_idx;
  logic [CW-1:0] cnt;
  logic          err_q, arb_any, active;

  rr_arbiter #(.N(N_DST), .PW(PW)) u_rr (
    .req     (SRC_REQ_IN),
    .ptr     (rr_ptr),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  assign active = (state == ARB_ACTIVE);

  always_ff @(posedge CLK or posedge RESET_IN) begin
    if (RESET_IN) begin
      state  <= ARB_IDLE;
      grant  <= '0;
      cnt    <= '0;
      rr_ptr <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (MEM_ACK_IN) err_q <= 1'b1;
          if (arb_any) begin
            grant <= arb_idx;
            cnt   <= '0;
            state <= ARB_ACTIVE;
          end
        end
        ARB_ACTIVE: begin
          // The core cannot abort a burst, so a dropped request only flags.
          if (!SRC_REQ_IN[grant]) err_q <= 1'b1;
          if (MEM_ACK_IN) begin
            if (cnt == CW'(NB - 1)) begin
              state  <= ARB_IDLE;
              rr_ptr <= (grant == PW'(N_DST - 1)) ? '0 : grant + 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign MEM_REQ_OUT   = active;
  assign MEM_WRITE_OUT = active & SRC_WRITE_IN[grant];
  assign MEM_ACS_OUT   = active ? SRC_ACS_IN[grant] : '0;
  assign ERR_OUT       = err_q;

  always_comb begin
    SRC_ACK_OUT = '0;
    if (active) SRC_ACK_OUT[grant] = MEM_ACK_IN;
  end

  // Read data is broadcast; the per-port ack bit is the only qualifier.
  for (genvar p = 0; p < N_DST; p++) begin : g_data
    assign SRC_DATA_OUT[p] = MEM_DATA_IN;
  end

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Responder for the SDRAM cache's downstream request/acknowledge ports: accepts N_DST independent burst requests (each port as driven by the cache's DST_WRITE_OUT / DST_ACS_OUT / DST_REQ_OUT / DST_ACK_IN / DST_DATA_IN bundle), arbitrates them round-robin, and forwards one burst at a time to the single command port of the SDRAM controller core. Read data and per-beat acknowledges are routed back to the granted port.

## Interface
Parameters:
- N_DST, 4, number of requesting ports (1..16).
- BURST, SDRAM_PKG::BURST_8, burst length; beats per transaction = SDRAM_PKG::N_BURSTS[BURST].

Ports:
- CLK  in  1  single clock for all logic.
- RESET_IN  in  1  asynchronous, active-high reset.
- SRC_WRITE_IN  in  [N_DST]  1 = write burst, 0 = read burst.
- SRC_ACS_IN  in  [N_DST] x dram_access_t  address plus current write beat data/mask.
- SRC_REQ_IN  in  [N_DST]  request; held until the last beat is acknowledged.
- SRC_ACK_OUT  out  [N_DST]  one-cycle pulse per beat, granted port only.
- SRC_DATA_OUT  out  [N_DST] x data_t  read data, valid with SRC_ACK_OUT.
- MEM_WRITE_OUT  out  1  forwarded write flag.
- MEM_ACS_OUT  out  dram_access_t  forwarded access.
- MEM_REQ_OUT  out  1  request to controller core.
- MEM_ACK_IN  in  1  per-beat acknowledge from core.
- MEM_DATA_IN  in  data_t  read beat data, valid with MEM_ACK_IN.
- ERR_OUT  out  1  sticky protocol error flag.

## Operation
- States: IDLE, ACTIVE.
- IDLE: MEM_REQ_OUT=0. If any SRC_REQ_IN is set, select the first requester at or after rr_ptr (wrapping from N_DST-1 to 0), register grant, clear beat count, go to ACTIVE.
- ACTIVE: MEM_REQ_OUT=1; MEM_WRITE_OUT/MEM_ACS_OUT = SRC_WRITE_IN/SRC_ACS_IN of the granted port (combinational mux, so the write data may advance per beat). SRC_ACK_OUT[grant] = MEM_ACK_IN; all other ACK bits are 0. MEM_DATA_IN is broadcast to every SRC_DATA_OUT; only the ACK bit qualifies it.
- Each MEM_ACK_IN increments beat count. When MEM_ACK_IN arrives with count == N_BURSTS-1: go to IDLE, set rr_ptr = grant+1 mod N_DST.
- Granted port drops SRC_REQ_IN before its final beat: the burst still completes (the core cannot abort), ERR_OUT is set and stays set until reset; the ACKs still pulse.
- A port re-raising REQ immediately after completion competes normally; it has the lowest round-robin priority.
- MEM_ACK_IN while IDLE: ignored; sets ERR_OUT.
- Reset (any time, including mid-burst): state IDLE, grant 0, count 0, rr_ptr 0, ERR_OUT 0, MEM_REQ_OUT 0, MEM_WRITE_OUT 0, MEM_ACS_OUT '0, all SRC_ACK_OUT 0. SRC_DATA_OUT follows MEM_DATA_IN.

## Timing
- REQ sampled high in IDLE at cycle 0: MEM_REQ_OUT high from cycle 1.
- ACK path MEM_ACK_IN -> SRC_ACK_OUT is combinational, with 0 cycles of latency. Data path is also combinational.
- Last ACK at cycle k: MEM_REQ_OUT low at cycle k+1 (IDLE). The next grant makes MEM_REQ_OUT high at k+2 at the earliest. There is exactly one bubble cycle between bursts.
- Beat counter width is $clog2(N_BURSTS), or 1 for a single-beat burst. Wrap-around is impossible because the state exits on the last beat.
- Back-to-back ACKs on consecutive cycles are supported.

## Structure
- SDRAM_PKG already provides burst_t, N_BURSTS, data_t and dram_access_t. Any new shared constants go there; none are local typedefs.
- Sub-module rr_arbiter (parameter N, inputs req[N] and ptr, outputs gnt_idx and any): a purely combinational first-set-at-or-after-ptr search. It is reused by other arbiters in the design.
- The FSM, counter, rr_ptr, grant register and ERR flag live in sdram_port_arbiter.

## Test plan
- Single read: N_DST=4, port 2 REQ, read, core ACKs 8 beats with data 0x1000..0x1007 -> SRC_ACK_OUT[2] pulses 8 times with matching data, MEM_REQ_OUT high for cycles 1..8 then low, other ACKs 0.
- Fairness: ports 0,1,3 all held requesting for 6 bursts -> grant order 0,1,3,0,1,3 with one idle cycle between bursts.
- Write data advance: port 1 write, ACS data changes 0xA0..0xA7 after each ACK, ACK stalls of 0–3 random cycles -> MEM_ACS_OUT shows 0xA0..0xA7 in order, each beat held until its ACK.
- Early drop: port 0 drops REQ after 3 ACKs -> the core still sees the request until 8 ACKs, ERR_OUT=1 from the drop cycle onward.
- Reset mid-burst: RESET_IN asserted after 4 beats -> MEM_REQ_OUT and ACKs go to 0 asynchronously. After release, a new request from port 3 is served first with rr_ptr=0 ordering.
- Spurious ACK: MEM_ACK_IN pulse while IDLE -> no SRC_ACK_OUT, ERR_OUT=1.
